div_ctrl: RTL and testbench

//  Multi-cycle 32/32 radix-2 restoring divider with sequencing FSM, serving the EX stage's DIV/DIVU ops.
//  EX raises start_i with operands; block holds EX via stallreq_o until result ready.
//  The 64-bit result {remainder, quotient} is written to HI/LO through the existing whilo path.

---
 rtl/div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_div_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for the EX stage DIV/DIVU ops.
// Holds EX through stallreq_o until {remainder, quotient} is ready for HI/LO.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_END    = 2'b11;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                a_neg_s, b_neg_s;
    logic [DATA_W:0]     shift_s, diff_s;

    function automatic logic [DATA_W-1:0] neg_f(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state, datapath step and result formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        a_neg_s  = signed_div_i & opdata1_i[DATA_W-1];
        b_neg_s  = signed_div_i & opdata2_i[DATA_W-1];
        // Partial remainder always stays below the divisor, so one extra bit suffices.
        shift_s  = {rem_q, quo_q[DATA_W-1]};
        diff_s   = shift_s - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                result_d = {(2*DATA_W){1'b0}};
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == DATA_ZERO) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = {CNT_W{1'b0}};
                        rem_d   = DATA_ZERO;
                        quo_d   = a_neg_s ? neg_f(opdata1_i) : opdata1_i;
                        dvs_d   = b_neg_s ? neg_f(opdata2_i) : opdata2_i;
                        qneg_d  = a_neg_s ^ b_neg_s;
                        rneg_d  = a_neg_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BYZERO: begin
                result_d = {(2*DATA_W){1'b0}};
                if (annul_i) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = {(2*DATA_W){1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {rneg_q ? neg_f(rem_q) : rem_q,
                                qneg_q ? neg_f(quo_q) : quo_q};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!diff_s[DATA_W]) begin
                        rem_d = diff_s[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shift_s[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = {(2*DATA_W){1'b0}};
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = {(2*DATA_W){1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            rem_q    <= DATA_ZERO;
            quo_q    <= DATA_ZERO;
            dvs_q    <= DATA_ZERO;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= {(2*DATA_W){1'b0}};
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    // Stall is held low while reset is asserted, whatever EX drives.
    assign stallreq_o = rst & start_i & ~annul_i & (state_q != S_END);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: latency/arithmetic model plus directed
// scenarios and randomized operations with flushes and operand scrambling.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks;
    int errors;

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op completes after a fixed number of edges.
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;
    int          m_ph;
    int          m_left;
    logic [63:0] m_res;
    logic        exp_ready;
    logic [63:0] exp_result;
    logic        exp_stall;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= PH_IDLE; m_left <= 0; m_res <= 64'd0;
            exp_ready <= 1'b0; exp_result <= 64'd0;
        end else begin
            case (m_ph)
                PH_IDLE: begin
                    if (start_i && !annul_i) begin
                        m_ph   <= PH_BUSY;
                        m_left <= (opdata2_i == 32'd0) ? 1 : 33;
                        m_res  <= div_ref(opdata1_i, opdata2_i, signed_div_i);
                    end
                end
                PH_BUSY: begin
                    if (annul_i) begin
                        m_ph <= PH_IDLE;
                    end else if (m_left == 1) begin
                        m_ph <= PH_DONE; exp_ready <= 1'b1; exp_result <= m_res;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: begin
                    if (annul_i || !start_i) begin
                        m_ph <= PH_IDLE; exp_ready <= 1'b0; exp_result <= 64'd0;
                    end
                end
            endcase
        end
    end

    assign exp_stall = rst && start_i && !annul_i && (m_ph != PH_DONE);

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        chk("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
        chk("result_o", result_o, exp_result);
        chk("stallreq_o", {63'd0, stallreq_o}, {63'd0, exp_stall});
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int hold, input bit scramble, input int abort_at,
                         input bit end_annul, output int lat, output logic [63:0] res);
        bit done;
        @(posedge clk); #1;
        opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
        lat = 0; res = 64'd0; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            lat++;
            if (scramble) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
            end
            if (ready_o) begin
                done = 1'b1;
            end else if (lat == abort_at) begin
                annul_i = 1'b1;
                @(posedge clk); #1;
                annul_i = 1'b0; start_i = 1'b0;
                @(posedge clk); #1;
                return;
            end else if (lat > 60) begin
                checks++; errors++;
                $display("FAIL ready_timeout actual=no_ready expected=ready_within_60");
                done = 1'b1;
            end
        end
        res = result_o;
        repeat (hold) begin @(posedge clk); #1; end
        if (end_annul) begin
            annul_i = 1'b1;
            @(posedge clk); #1;
            annul_i = 1'b0;
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [31:0] a, b;
        logic        sgn;
        int          sel;
        checks = 0; errors = 0;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;

        // Hand-computed values pinning the reference model.
        chk("pin_divu_100_7", div_ref(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        chk("pin_div_m7_2", div_ref(32'hFFFFFFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        chk("pin_div_7_m2", div_ref(32'd7, 32'hFFFFFFFE, 1'b1), 64'h00000001_FFFFFFFD);
        chk("pin_div_ovf", div_ref(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        rst = 1'b1;

        do_op(32'd100, 32'd7, 1'b0, 0, 1'b0, -1, 1'b0, lat, res);
        chk("divu_latency", 64'(lat), 64'd34);
        chk("divu_result", res, 64'h00000002_0000000E);
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b0, -1, 1'b0, lat, res);
        chk("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
        do_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 1'b0, -1, 1'b0, lat, res);
        chk("div_7_m2", res, 64'h00000001_FFFFFFFD);
        do_op(32'd5, 32'd0, 1'b0, 0, 1'b0, -1, 1'b0, lat, res);
        chk("byzero_latency", 64'(lat), 64'd2);
        chk("byzero_result", res, 64'd0);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0, -1, 1'b0, lat, res);
        chk("div_ovf", res, 64'h00000000_80000000);

        // Flush at cycle 10 of ON: stall must fall in the annul cycle itself.
        @(posedge clk); #1;
        opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        #1;
        chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        repeat (3) begin @(posedge clk); #1; end

        // Asynchronous reset at cycle 20 of ON.
        opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
        repeat (21) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        chk("rst_mid_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        do_op(32'd9, 32'd3, 1'b0, 0, 1'b0, -1, 1'b0, lat, res);
        chk("after_rst_9_3", res, 64'h00000000_00000003);

        // Held start in END plus operand scrambling while ON.
        do_op(32'd1000, 32'd3, 1'b0, 5, 1'b1, -1, 1'b0, lat, res);
        chk("hold_scramble", res, {32'd1, 32'd333});

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom; b = $urandom; sgn = 1'($urandom);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; sgn = 1'b1; end
            else if (sel < 5) b = $urandom_range(1, 20);
            else if (sel == 5) b = {{16{b[31]}}, b[15:0]};
            do_op(a, b, sgn, $urandom_range(0, 4), 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, 34) : -1,
                  ($urandom_range(0, 5) == 0), lat, res);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
